// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_t     : arbiter FSM states (IDLE, WAIT, GAP)
//   UART_DATA_W : width of one UART payload byte
package uart_pkg;

   localparam int UART_DATA_W = 8;

   // IDLE : sample requests, pick a winner
   // WAIT : frame in flight, waiting for the transmitter's done pulse
   // GAP  : one-cycle turnaround with the grant already released
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      GAP  = 2'd2
   } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//   valid      : per-requester request vector
//   ptr        : index of the highest-priority requester
//   winner     : one-hot winner (all zero when nothing is valid)
//   winner_idx : binary index of the winner
// The valid vector is rotated so that ptr lands at bit 0, the lowest set bit
// is found, and the offset is added back to ptr modulo N_REQ.
module uart_rr_pick #(
   parameter int N_REQ = 4,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] winner,
   output logic [PW-1:0]    winner_idx
);

   localparam logic [PW:0] N_L = (PW+1)'(N_REQ);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   logic [PW-1:0]      offs;
   logic [PW:0]        sum;

   always_comb begin
      dbl  = {valid, valid};
      rot  = N_REQ'(dbl >> ptr);
      offs = '0;
      // Descending scan so the lowest set bit (closest to ptr) wins.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) offs = PW'(i);
      end
      sum = {1'b0, ptr} + {1'b0, offs};
      if (sum >= N_L) sum = sum - N_L;
      winner_idx = sum[PW-1:0];
      winner     = '0;
      if (|valid) winner[winner_idx] = 1'b1;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers.
//   clk, reset     : clock, synchronous active-high reset
//   i_req_valid    : per-requester byte valid, held until its ready pulse
//   i_req_data     : requester k byte at [8k+7:8k]
//   o_req_ready    : one-cycle one-hot accept pulse
//   o_grant        : one-hot owner of the current frame
//   o_tx_start     : one-cycle start pulse to the UART TX
//   o_tx_data      : byte to the UART TX, held until the next accept
//   i_tx_done      : one-cycle pulse from the UART TX at end of stop bit
//   o_busy         : high from the accept cycle through GAP
//   o_timeout_err  : sticky frame-timeout flag, cleared by i_err_clr
//   o_err_src      : requester index of the most recent timed-out frame
// Handshake: a requester holds valid and data stable; the arbiter samples
// them only in IDLE and answers with a single-cycle ready on the accept edge.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 200000
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [N_REQ-1:0]             i_req_valid,
   input  logic [UART_DATA_W*N_REQ-1:0] i_req_data,
   output logic [N_REQ-1:0]             o_req_ready,
   output logic [N_REQ-1:0]             o_grant,
   output logic                         o_tx_start,
   output logic [UART_DATA_W-1:0]       o_tx_data,
   input  logic                         i_tx_done,
   output logic                         o_busy,
   output logic                         o_timeout_err,
   output logic [$clog2(N_REQ)-1:0]     o_err_src,
   input  logic                         i_err_clr
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);

   state_t                 state, state_next;
   logic [PW-1:0]          ptr, cur_idx, pick_idx;
   logic [N_REQ-1:0]       pick_oh;
   logic [CW-1:0]          cnt;
   logic [UART_DATA_W-1:0] pick_data;
   logic                   accept, done_seen, to_fire;

   uart_rr_pick #(.N_REQ(N_REQ), .PW(PW)) u_pick (
      .valid      (i_req_valid),
      .ptr        (ptr),
      .winner     (pick_oh),
      .winner_idx (pick_idx)
   );

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) pick_data = i_req_data[i*UART_DATA_W +: UART_DATA_W];
      end
   end

   // The start register marks the first WAIT cycle; done is ignored there.
   assign accept    = (state == IDLE) && (|i_req_valid);
   assign done_seen = (state == WAIT) && !o_tx_start && i_tx_done;
   assign to_fire   = (state == WAIT) && !done_seen && (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = WAIT;
         WAIT:    if (done_seen || to_fire) state_next = GAP;
         GAP:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      o_busy = (state != IDLE);
   end

   // Accept datapath, grant, pointer and frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         o_req_ready <= '0;
         o_tx_start  <= 1'b0;
         o_grant     <= '0;
         o_tx_data   <= '0;
         ptr         <= '0;
         cur_idx     <= '0;
         cnt         <= '0;
      end else begin
         o_req_ready <= '0;
         o_tx_start  <= 1'b0;
         if (accept) begin
            o_req_ready <= pick_oh;
            o_tx_start  <= 1'b1;
            o_grant     <= pick_oh;
            o_tx_data   <= pick_data;
            cur_idx     <= pick_idx;
            ptr         <= (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
            cnt         <= '0;
         end else if (state == WAIT) begin
            // The frame leaves WAIT at CNT_LAST, so the counter never wraps.
            cnt <= cnt + 1'b1;
            if (done_seen || to_fire) o_grant <= '0;
         end
      end
   end

   // Sticky error: a timeout wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_timeout_err <= 1'b0;
         o_err_src     <= '0;
      end else if (to_fire) begin
         o_timeout_err <= 1'b1;
         o_err_src     <= cur_idx;
      end else if (i_err_clr) begin
         o_timeout_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with N_REQ=4, TIMEOUT=50.
module tb_uart_tx_arbiter;

   localparam int N_REQ   = 4;
   localparam int TIMEOUT = 50;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  i_req_valid;
   logic [31:0] i_req_data;
   logic [3:0]  o_req_ready;
   logic [3:0]  o_grant;
   logic        o_tx_start;
   logic [7:0]  o_tx_data;
   logic        i_tx_done;
   logic        o_busy;
   logic        o_timeout_err;
   logic [1:0]  o_err_src;
   logic        i_err_clr;

   int n_vec = 0;
   int n_err = 0;

   uart_tx_arbiter #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_req_valid   (i_req_valid),
      .i_req_data    (i_req_data),
      .o_req_ready   (o_req_ready),
      .o_grant       (o_grant),
      .o_tx_start    (o_tx_start),
      .o_tx_data     (o_tx_data),
      .i_tx_done     (i_tx_done),
      .o_busy        (o_busy),
      .o_timeout_err (o_timeout_err),
      .o_err_src     (o_err_src),
      .i_err_clr     (i_err_clr)
   );

   always #5 clk = ~clk;

   // Advance one cycle; observe registered outputs 1ns after the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string name);
      int w = 0;
      while (!o_tx_start && w < 12) begin
         tick();
         w++;
      end
      n_vec++;
      if (o_tx_start !== 1'b1) begin
         n_err++;
         $display("FAIL %s_start: start=%b after %0d cycles, required 1", name, o_tx_start, w);
      end
   endtask

   // One complete frame: accept, hold in WAIT, done pulse, GAP, IDLE.
   task automatic do_frame(input int k, input logic [7:0] d, input logic [3:0] nv, input int hold);
      logic [3:0] exp_oh;
      exp_oh = 4'b0001 << k;
      wait_start("frame");
      n_vec++;
      if (o_grant !== exp_oh) begin n_err++; $display("FAIL frame_grant: got %b, required %b", o_grant, exp_oh); end
      n_vec++;
      if (o_req_ready !== exp_oh) begin n_err++; $display("FAIL frame_ready: got %b, required %b", o_req_ready, exp_oh); end
      n_vec++;
      if (o_tx_data !== d) begin n_err++; $display("FAIL frame_data: got %h, required %h", o_tx_data, d); end
      n_vec++;
      if (o_busy !== 1'b1) begin n_err++; $display("FAIL frame_busy: got %b, required 1", o_busy); end
      tick();
      n_vec++;
      if ({o_req_ready, o_tx_start, o_grant} !== {4'b0000, 1'b0, exp_oh}) begin
         n_err++;
         $display("FAIL frame_pulse_end: ready=%b start=%b grant=%b, required 0000 0 %b", o_req_ready, o_tx_start, o_grant, exp_oh);
      end
      repeat (hold) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_vec++;
      if ({o_grant, o_busy, o_tx_start, o_tx_data} !== {4'b0000, 1'b1, 1'b0, d}) begin
         n_err++;
         $display("FAIL frame_gap: grant=%b busy=%b start=%b data=%h, required 0000 1 0 %h", o_grant, o_busy, o_tx_start, o_tx_data, d);
      end
      i_req_valid = nv;
      tick();
      n_vec++;
      if ({o_busy, o_tx_start} !== 2'b00) begin
         n_err++;
         $display("FAIL frame_idle: busy=%b start=%b, required 0 0", o_busy, o_tx_start);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      i_req_valid = '0;
      i_req_data = '0;
      i_tx_done = 1'b0;
      i_err_clr = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout_err, o_err_src} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_outputs: ready=%b grant=%b start=%b data=%h busy=%b err=%b src=%0d, required all 0",
                  o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout_err, o_err_src);
      end
      reset = 1'b0;
      tick();
      n_vec++;
      if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle: busy=%b, required 0", o_busy); end
   endtask

   task automatic test_single;
      i_req_data = 32'h00_00_A5_00;
      i_req_valid = 4'b0010;
      do_frame(1, 8'hA5, 4'b0000, 28);
   endtask

   task automatic test_all_valid;
      i_req_data = 32'h43_32_21_10;
      i_req_valid = 4'b1111;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      do_frame(0, 8'h10, 4'b1111, 2);
      do_frame(1, 8'h21, 4'b1111, 2);
      do_frame(2, 8'h32, 4'b1111, 2);
      do_frame(3, 8'h43, 4'b1111, 2);
      do_frame(0, 8'h10, 4'b0000, 2);
   endtask

   task automatic test_wrap;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      i_req_data = 32'h33_5A_00_11;
      i_req_valid = 4'b0100;
      do_frame(2, 8'h5A, 4'b0100, 3);
      do_frame(2, 8'h5A, 4'b1001, 3);
      do_frame(3, 8'h33, 4'b1001, 3);
      do_frame(0, 8'h11, 4'b0000, 3);
   endtask

   task automatic test_done_in_start;
      i_req_data = 32'h00_6C_00_00;
      i_req_valid = 4'b0100;
      wait_start("done_in_start");
      i_tx_done = 1'b1;
      i_req_valid = '0;
      tick();
      i_tx_done = 1'b0;
      n_vec++;
      if ({o_grant, o_busy} !== {4'b0100, 1'b1}) begin
         n_err++;
         $display("FAIL done_in_start_ignored: grant=%b busy=%b, required 0100 1", o_grant, o_busy);
      end
      repeat (3) tick();
      n_vec++;
      if ({o_grant, o_busy} !== {4'b0100, 1'b1}) begin
         n_err++;
         $display("FAIL done_in_start_hold: grant=%b busy=%b, required 0100 1", o_grant, o_busy);
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_vec++;
      if ({o_grant, o_busy} !== {4'b0000, 1'b1}) begin
         n_err++;
         $display("FAIL done_in_start_gap: grant=%b busy=%b, required 0000 1", o_grant, o_busy);
      end
      tick();
   endtask

   task automatic test_timeout;
      // Req0 times out: start cycle is WAIT cycle 1, expiry on the 50th.
      i_req_data = 32'h99_88_00_77;
      i_req_valid = 4'b0001;
      wait_start("timeout_a");
      i_req_valid = '0;
      repeat (TIMEOUT - 1) tick();
      n_vec++;
      if ({o_timeout_err, o_grant, o_busy} !== {1'b0, 4'b0001, 1'b1}) begin
         n_err++;
         $display("FAIL timeout_before: err=%b grant=%b busy=%b, required 0 0001 1", o_timeout_err, o_grant, o_busy);
      end
      tick();
      n_vec++;
      if ({o_timeout_err, o_err_src, o_grant, o_busy} !== {1'b1, 2'd0, 4'b0000, 1'b1}) begin
         n_err++;
         $display("FAIL timeout_fire: err=%b src=%0d grant=%b busy=%b, required 1 0 0000 1", o_timeout_err, o_err_src, o_grant, o_busy);
      end
      tick();
      n_vec++;
      if ({o_timeout_err, o_busy} !== 2'b10) begin
         n_err++;
         $display("FAIL timeout_sticky: err=%b busy=%b, required 1 0", o_timeout_err, o_busy);
      end
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      n_vec++;
      if (o_timeout_err !== 1'b0) begin n_err++; $display("FAIL timeout_clear: err=%b, required 0", o_timeout_err); end

      // Req2: done arrives in the expiry cycle, so no error.
      i_req_valid = 4'b0100;
      wait_start("timeout_c");
      i_req_valid = '0;
      repeat (TIMEOUT - 1) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_vec++;
      if ({o_timeout_err, o_grant, o_busy} !== {1'b0, 4'b0000, 1'b1}) begin
         n_err++;
         $display("FAIL timeout_done_wins: err=%b grant=%b busy=%b, required 0 0000 1", o_timeout_err, o_grant, o_busy);
      end
      tick();

      // Req3 times out while a clear is applied on the same edge.
      i_req_valid = 4'b1000;
      wait_start("timeout_b");
      i_req_valid = '0;
      repeat (TIMEOUT - 1) tick();
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      n_vec++;
      if ({o_timeout_err, o_err_src} !== {1'b1, 2'd3}) begin
         n_err++;
         $display("FAIL timeout_set_over_clr: err=%b src=%0d, required 1 3", o_timeout_err, o_err_src);
      end
      tick();
   endtask

   task automatic test_reset_mid;
      i_req_data = 32'h00_00_C3_00;
      i_req_valid = 4'b0010;
      wait_start("reset_mid");
      i_req_valid = '0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_vec++;
      if ({o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout_err, o_err_src} !== 21'd0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: ready=%b grant=%b start=%b data=%h busy=%b err=%b src=%0d, required all 0",
                  o_req_ready, o_grant, o_tx_start, o_tx_data, o_busy, o_timeout_err, o_err_src);
      end
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      n_vec++;
      if ({o_grant, o_busy, o_req_ready} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_mid_late_done: grant=%b busy=%b ready=%b, required 0000 0 0000", o_grant, o_busy, o_req_ready);
      end
      // Pointer was 2 before reset; req0 winning shows it returned to 0.
      i_req_data = 32'h44_33_22_11;
      i_req_valid = 4'b1111;
      tick();
      i_req_valid = '0;
      n_vec++;
      if ({o_grant, o_tx_start, o_tx_data} !== {4'b0001, 1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL reset_mid_ptr: grant=%b start=%b data=%h, required 0001 1 11", o_grant, o_tx_start, o_tx_data);
      end
      tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_valid();
      test_wrap();
      test_done_in_start();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
